// File: rtl/mlaccel_main_memory.sv
// Main 128 KiB accelerator memory: four 16K x 16 banks behind one 64-bit, four-word port
// that accepts any word address. Two-cycle pipelined access, read-first on writes.
module mlaccel_main_memory (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wen,
    input  logic [63:0] wdata,
    output logic [63:0] rdata
);
    logic [15:0] s1_addr;
    logic [7:0]  s1_wen;
    logic [63:0] s1_wdata;
    logic [1:0]  s2_off;

    logic [1:0]  bank_lane  [4];
    logic [13:0] bank_idx   [4];
    logic [15:0] bank_wdata [4];
    logic [1:0]  bank_be    [4];
    logic [15:0] bank_q     [4];
    logic [1:0]  out_bank   [4];

    logic [15:0] mem [4][16384];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_addr  <= '0;
            s1_wen   <= '0;
            s1_wdata <= '0;
        end else begin
            s1_addr  <= addr;
            s1_wen   <= wen;
            s1_wdata <= wdata;
        end
    end

    // Bank b serves lane (b - A[1:0]); its row steps past A[15:2] when that lane wrapped a row.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bank_lane[b]  = 2'(b) - s1_addr[1:0];
            bank_idx[b]   = s1_addr[15:2] + {13'd0, (2'(b) < s1_addr[1:0])};
            bank_wdata[b] = s1_wdata[16*bank_lane[b] +: 16];
            bank_be[b]    = s1_wen[2*bank_lane[b] +: 2];
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (bank_be[b][0]) mem[b][bank_idx[b]][7:0]  <= bank_wdata[b][7:0];
            if (bank_be[b][1]) mem[b][bank_idx[b]][15:8] <= bank_wdata[b][15:8];
        end
    end

    // Non-blocking read alongside the write above gives read-first behaviour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_off <= '0;
            for (int b = 0; b < 4; b++) bank_q[b] <= '0;
        end else begin
            s2_off <= s1_addr[1:0];
            for (int b = 0; b < 4; b++) bank_q[b] <= mem[b][bank_idx[b]];
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 4; k++) begin
            out_bank[k]       = 2'(k) + s2_off;
            rdata[16*k +: 16] = bank_q[out_bank[k]];
        end
    end
endmodule

// File: tb/tb_mlaccel_main_memory.sv
// Directed bench for mlaccel_main_memory: lane mapping, wrap, byte masks, pipelining, reset.
module tb_mlaccel_main_memory;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr  = '0;
    logic [7:0]  wen   = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mlaccel_main_memory dut (
        .clock(clock),
        .reset(reset),
        .addr (addr),
        .wen  (wen),
        .wdata(wdata),
        .rdata(rdata)
    );

    // Word w of the streaming region holds 16'hA000 + w.
    function automatic logic [63:0] stream_exp(input int a);
        logic [63:0] e;
        e = '0;
        for (int k = 0; k < 4; k++) e[16*k +: 16] = 16'(16'hA000 + a + k);
        return e;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [7:0] w, input logic [63:0] d);
        @(negedge clock);
        addr  = a;
        wen   = w;
        wdata = d;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [63:0] q);
        drive(a, 8'h00, 64'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        q = rdata;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata got=%h exp=%h", rdata, 64'h0);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_aligned;
        logic [63:0] q;
        drive(16'h0000, 8'hFF, 64'h4444_3333_2222_1111);
        do_read(16'h0000, q);
        checks++;
        if (q !== 64'h4444_3333_2222_1111) begin
            errors++;
            $display("FAIL aligned_read got=%h exp=%h", q, 64'h4444_3333_2222_1111);
        end
    endtask

    task automatic test_unaligned;
        logic [63:0] q;
        drive(16'h0004, 8'h03, 64'h0000_0000_0000_5555);
        do_read(16'h0001, q);
        checks++;
        if (q !== 64'h5555_4444_3333_2222) begin
            errors++;
            $display("FAIL unaligned_read got=%h exp=%h", q, 64'h5555_4444_3333_2222);
        end
    endtask

    task automatic test_wrap;
        logic [63:0] q;
        drive(16'hFFFF, 8'hFF, 64'hDDDD_CCCC_BBBB_AAAA);
        do_read(16'h0000, q);
        checks++;
        if (q !== 64'h4444_DDDD_CCCC_BBBB) begin
            errors++;
            $display("FAIL wrap_read0 got=%h exp=%h", q, 64'h4444_DDDD_CCCC_BBBB);
        end
        do_read(16'hFFFF, q);
        checks++;
        if (q !== 64'hDDDD_CCCC_BBBB_AAAA) begin
            errors++;
            $display("FAIL wrap_readffff got=%h exp=%h", q, 64'hDDDD_CCCC_BBBB_AAAA);
        end
        drive(16'hFFFF, 8'h03, 64'h0000_0000_0000_EEEE);
        do_read(16'hFFFF, q);
        checks++;
        if (q[31:0] !== 32'hBBBB_EEEE) begin
            errors++;
            $display("FAIL wrap_fetch32 got=%h exp=%h", q[31:0], 32'hBBBB_EEEE);
        end
    endtask

    task automatic test_byte_mask;
        logic [63:0] q;
        drive(16'h0005, 8'h03, 64'h0000_0000_0000_1234);
        drive(16'h0006, 8'h03, 64'h0000_0000_0000_5678);
        drive(16'h0005, 8'h02, 64'h0000_0000_0000_AB00);
        drive(16'h0005, 8'h04, 64'h0000_0000_00CD_0000);
        do_read(16'h0005, q);
        checks++;
        if (q[15:0] !== 16'hAB34) begin
            errors++;
            $display("FAIL mask_high_byte got=%h exp=%h", q[15:0], 16'hAB34);
        end
        checks++;
        if (q[31:16] !== 16'h56CD) begin
            errors++;
            $display("FAIL mask_lane1_low got=%h exp=%h", q[31:16], 16'h56CD);
        end
    endtask

    task automatic test_back_to_back;
        drive(16'h0008, 8'hFF, 64'h1818_1717_1616_1515);
        drive(16'h0008, 8'hFF, 64'h2828_2727_2626_2525);
        @(posedge clock);
        drive(16'h0008, 8'h00, 64'h0);
        @(posedge clock);
        #1;
        checks++;
        if (rdata !== 64'h1818_1717_1616_1515) begin
            errors++;
            $display("FAIL rdw_old got=%h exp=%h", rdata, 64'h1818_1717_1616_1515);
        end
        drive(16'h0000, 8'h00, 64'h0);
        @(posedge clock);
        #1;
        checks++;
        if (rdata !== 64'h2828_2727_2626_2525) begin
            errors++;
            $display("FAIL rdw_new got=%h exp=%h", rdata, 64'h2828_2727_2626_2525);
        end
        drive(16'd16, 8'hFF, stream_exp(16));
        drive(16'd20, 8'hFF, stream_exp(20));
        drive(16'd24, 8'hFF, stream_exp(24));
        for (int i = 0; i < 8; i++) begin
            drive(16'(16 + i), 8'h00, 64'h0);
            @(posedge clock);
            #1;
            if (i > 0) begin
                checks++;
                if (rdata !== stream_exp(16 + i - 1)) begin
                    errors++;
                    $display("FAIL stream_%0d got=%h exp=%h", i - 1, rdata, stream_exp(16 + i - 1));
                end
            end
        end
        drive(16'h0000, 8'h00, 64'h0);
        @(posedge clock);
        #1;
        checks++;
        if (rdata !== stream_exp(23)) begin
            errors++;
            $display("FAIL stream_7 got=%h exp=%h", rdata, stream_exp(23));
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] q;
        drive(16'd10, 8'hFF, 64'h6363_6262_6161_6060);
        do_read(16'd10, q);
        checks++;
        if (q !== 64'h6363_6262_6161_6060) begin
            errors++;
            $display("FAIL pre_reset_word10 got=%h exp=%h", q, 64'h6363_6262_6161_6060);
        end
        drive(16'd10, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_async_rdata got=%h exp=%h", rdata, 64'h0);
        end
        drive(16'h0000, 8'h00, 64'h0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_held_rdata got=%h exp=%h", rdata, 64'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        do_read(16'd10, q);
        checks++;
        if (q !== 64'h6363_6262_6161_6060) begin
            errors++;
            $display("FAIL dropped_write got=%h exp=%h", q, 64'h6363_6262_6161_6060);
        end
        do_read(16'h0000, q);
        checks++;
        if (q !== 64'h4444_DDDD_CCCC_BBBB) begin
            errors++;
            $display("FAIL post_reset_word0 got=%h exp=%h", q, 64'h4444_DDDD_CCCC_BBBB);
        end
        do_read(16'h0008, q);
        checks++;
        if (q !== 64'h6161_6060_2626_2525) begin
            errors++;
            $display("FAIL post_reset_word8 got=%h exp=%h", q, 64'h6161_6060_2626_2525);
        end
        do_read(16'h0005, q);
        checks++;
        if (q[31:0] !== 32'h56CD_AB34) begin
            errors++;
            $display("FAIL post_reset_word5 got=%h exp=%h", q[31:0], 32'h56CD_AB34);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_wrap();
        test_byte_mask();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
